regfile_4r2w_64x24_ctl: RTL and testbench

- Port controller directly upstream of the 4R2W 64x24 toysram regfile macro.
- Registers binary read/write requests and drives the macro's predecoded one-hot address groups; port enable is encoded in the c_a0/c_na0 pair.
- Captures the macro's combinational read data and resolves write-write collisions.
- Optional write-to-read bypass.

---
 rtl/regfile_4r2w_64x24_ctl_if.sv | 86 ++++++++
 rtl/regfile_4r2w_64x24_ctl.sv | 173 +++++++++++++++++
 tb/tb_regfile_4r2w_64x24_ctl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_4r2w_64x24_ctl_if.sv
// Request and macro-side bundle for the 4R2W 64x24 regfile port controller.
// slave = controller view, master = requester/macro view.
interface regfile_4r2w_64x24_ctl_if #(
    parameter int CNT_W = 8
);
    logic        rd_en_i      [4];
    logic [0:5]  rd_adr_i     [4];
    logic        wr_en_i      [2];
    logic [0:5]  wr_adr_i     [2];
    logic [0:23] wr_dat_i     [2];
    logic [0:23] rd_dat_arr_i [4];

    logic rd_c_na0_o    [4];
    logic rd_c_a0_o     [4];
    logic rd_na1_na2_o  [4];
    logic rd_na1_a2_o   [4];
    logic rd_a1_na2_o   [4];
    logic rd_a1_a2_o    [4];
    logic rd_na3_o      [4];
    logic rd_a3_o       [4];
    logic rd_na4_na5_o  [4];
    logic rd_na4_a5_o   [4];
    logic rd_a4_na5_o   [4];
    logic rd_a4_a5_o    [4];

    logic wr_c_na0_o    [2];
    logic wr_c_a0_o     [2];
    logic wr_na1_na2_o  [2];
    logic wr_na1_a2_o   [2];
    logic wr_a1_na2_o   [2];
    logic wr_a1_a2_o    [2];
    logic wr_na3_o      [2];
    logic wr_a3_o       [2];
    logic wr_na4_na5_o  [2];
    logic wr_na4_a5_o   [2];
    logic wr_a4_na5_o   [2];
    logic wr_a4_a5_o    [2];

    logic [0:23]      wr_dat_arr_o [2];
    logic [0:23]      rd_dat_o     [4];
    logic             rd_val_o     [4];
    logic             wr_coll_o;
    logic [CNT_W-1:0] coll_cnt_o;

    modport slave (
        input  rd_en_i, rd_adr_i,
        input  wr_en_i, wr_adr_i, wr_dat_i,
        input  rd_dat_arr_i,
        output rd_c_na0_o, rd_c_a0_o,
        output rd_na1_na2_o, rd_na1_a2_o,
        output rd_a1_na2_o, rd_a1_a2_o,
        output rd_na3_o, rd_a3_o,
        output rd_na4_na5_o, rd_na4_a5_o,
        output rd_a4_na5_o, rd_a4_a5_o,
        output wr_c_na0_o, wr_c_a0_o,
        output wr_na1_na2_o, wr_na1_a2_o,
        output wr_a1_na2_o, wr_a1_a2_o,
        output wr_na3_o, wr_a3_o,
        output wr_na4_na5_o, wr_na4_a5_o,
        output wr_a4_na5_o, wr_a4_a5_o,
        output wr_dat_arr_o,
        output rd_dat_o, rd_val_o,
        output wr_coll_o, coll_cnt_o
    );

    modport master (
        output rd_en_i, rd_adr_i,
        output wr_en_i, wr_adr_i, wr_dat_i,
        output rd_dat_arr_i,
        input  rd_c_na0_o, rd_c_a0_o,
        input  rd_na1_na2_o, rd_na1_a2_o,
        input  rd_a1_na2_o, rd_a1_a2_o,
        input  rd_na3_o, rd_a3_o,
        input  rd_na4_na5_o, rd_na4_a5_o,
        input  rd_a4_na5_o, rd_a4_a5_o,
        input  wr_c_na0_o, wr_c_a0_o,
        input  wr_na1_na2_o, wr_na1_a2_o,
        input  wr_a1_na2_o, wr_a1_a2_o,
        input  wr_na3_o, wr_a3_o,
        input  wr_na4_na5_o, wr_na4_a5_o,
        input  wr_a4_na5_o, wr_a4_a5_o,
        input  wr_dat_arr_o,
        input  rd_dat_o, rd_val_o,
        input  wr_coll_o, coll_cnt_o
    );
endinterface

// File: rtl/regfile_4r2w_64x24_ctl.sv
// Port controller for the 4R2W 64x24 regfile macro: launch, predecode, capture.
// Optional write-to-read bypass: define REGFILE_CTL_BYPASS_EN.
module regfile_4r2w_64x24_ctl #(
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    regfile_4r2w_64x24_ctl_if.slave bus
);
    localparam int ADR_W = 6;
    localparam int DAT_W = 24;
    localparam int NRD   = 4;
    localparam int NWR   = 2;

    // bit order: c_na0 c_a0 na1na2 na1a2 a1na2 a1a2 na3 a3 na4na5 na4a5 a4na5 a4a5
    typedef logic [11:0] pd_t;

    function automatic pd_t predec(
        input logic             en,
        input logic [0:ADR_W-1] a
    );
        pd_t p;
        p = '0;
        if (en) begin
            p[11] = ~a[0];
            p[10] =  a[0];
            p[9]  = ~a[1] & ~a[2];
            p[8]  = ~a[1] &  a[2];
            p[7]  =  a[1] & ~a[2];
            p[6]  =  a[1] &  a[2];
            p[5]  = ~a[3];
            p[4]  =  a[3];
            p[3]  = ~a[4] & ~a[5];
            p[2]  = ~a[4] &  a[5];
            p[1]  =  a[4] & ~a[5];
            p[0]  =  a[4] &  a[5];
        end
        return p;
    endfunction

    logic             rd_en_q  [NRD];
    logic             rd_en_d  [NRD];
    logic [0:ADR_W-1] rd_adr_q [NRD];
    logic [0:ADR_W-1] rd_adr_d [NRD];
    logic             wr_en_q  [NWR];
    logic             wr_en_d  [NWR];
    logic [0:ADR_W-1] wr_adr_q [NWR];
    logic [0:ADR_W-1] wr_adr_d [NWR];
    logic [0:DAT_W-1] wr_dat_q [NWR];
    logic [0:DAT_W-1] wr_dat_d [NWR];
    logic [0:DAT_W-1] rd_dat_q [NRD];
    logic [0:DAT_W-1] rd_dat_d [NRD];
    logic             rd_val_q [NRD];
    logic             rd_val_d [NRD];
    logic             coll_q;
    logic             coll_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [0:DAT_W-1] cap_dat  [NRD];
    pd_t              rd_pd    [NRD];
    pd_t              wr_pd    [NWR];

    // Launch stage next state; a colliding wr0 is dropped so wr1 wins.
    always_comb begin
        coll_d = bus.wr_en_i[0] & bus.wr_en_i[1]
               & (bus.wr_adr_i[0] == bus.wr_adr_i[1]);
        for (int n = 0; n < NRD; n++) begin
            rd_en_d[n]  = bus.rd_en_i[n];
            rd_adr_d[n] = bus.rd_adr_i[n];
        end
        wr_en_d[0] = bus.wr_en_i[0] & ~coll_d;
        wr_en_d[1] = bus.wr_en_i[1];
        for (int m = 0; m < NWR; m++) begin
            wr_adr_d[m] = bus.wr_adr_i[m];
            wr_dat_d[m] = bus.wr_dat_i[m];
        end
        cnt_d = cnt_q;
        if (coll_d && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Capture source select: macro data, or a launched write when bypassing.
    always_comb begin
        for (int n = 0; n < NRD; n++) begin
            cap_dat[n] = bus.rd_dat_arr_i[n];
`ifdef REGFILE_CTL_BYPASS_EN
            if (wr_en_q[1] && (wr_adr_q[1] == rd_adr_q[n]))
                cap_dat[n] = wr_dat_q[1];
            else if (wr_en_q[0] && (wr_adr_q[0] == rd_adr_q[n]))
                cap_dat[n] = wr_dat_q[0];
`endif
            rd_val_d[n] = rd_en_q[n];
            rd_dat_d[n] = rd_en_q[n] ? cap_dat[n] : rd_dat_q[n];
        end
    end

    // Launch and capture registers; reset drops all in-flight requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NRD; n++) begin
                rd_en_q[n]  <= 1'b0;
                rd_adr_q[n] <= '0;
                rd_dat_q[n] <= '0;
                rd_val_q[n] <= 1'b0;
            end
            for (int m = 0; m < NWR; m++) begin
                wr_en_q[m]  <= 1'b0;
                wr_adr_q[m] <= '0;
                wr_dat_q[m] <= '0;
            end
            coll_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            for (int n = 0; n < NRD; n++) begin
                rd_en_q[n]  <= rd_en_d[n];
                rd_adr_q[n] <= rd_adr_d[n];
                rd_dat_q[n] <= rd_dat_d[n];
                rd_val_q[n] <= rd_val_d[n];
            end
            for (int m = 0; m < NWR; m++) begin
                wr_en_q[m]  <= wr_en_d[m];
                wr_adr_q[m] <= wr_adr_d[m];
                wr_dat_q[m] <= wr_dat_d[m];
            end
            coll_q <= coll_d;
            cnt_q  <= cnt_d;
        end
    end

    // Predecode straight from the launch registers.
    always_comb begin
        for (int n = 0; n < NRD; n++)
            rd_pd[n] = predec(rd_en_q[n], rd_adr_q[n]);
        for (int m = 0; m < NWR; m++)
            wr_pd[m] = predec(wr_en_q[m], wr_adr_q[m]);
    end

    for (genvar n = 0; n < NRD; n++) begin : g_rd
        assign bus.rd_c_na0_o[n]   = rd_pd[n][11];
        assign bus.rd_c_a0_o[n]    = rd_pd[n][10];
        assign bus.rd_na1_na2_o[n] = rd_pd[n][9];
        assign bus.rd_na1_a2_o[n]  = rd_pd[n][8];
        assign bus.rd_a1_na2_o[n]  = rd_pd[n][7];
        assign bus.rd_a1_a2_o[n]   = rd_pd[n][6];
        assign bus.rd_na3_o[n]     = rd_pd[n][5];
        assign bus.rd_a3_o[n]      = rd_pd[n][4];
        assign bus.rd_na4_na5_o[n] = rd_pd[n][3];
        assign bus.rd_na4_a5_o[n]  = rd_pd[n][2];
        assign bus.rd_a4_na5_o[n]  = rd_pd[n][1];
        assign bus.rd_a4_a5_o[n]   = rd_pd[n][0];
        assign bus.rd_dat_o[n]     = rd_dat_q[n];
        assign bus.rd_val_o[n]     = rd_val_q[n];
    end

    for (genvar m = 0; m < NWR; m++) begin : g_wr
        assign bus.wr_c_na0_o[m]   = wr_pd[m][11];
        assign bus.wr_c_a0_o[m]    = wr_pd[m][10];
        assign bus.wr_na1_na2_o[m] = wr_pd[m][9];
        assign bus.wr_na1_a2_o[m]  = wr_pd[m][8];
        assign bus.wr_a1_na2_o[m]  = wr_pd[m][7];
        assign bus.wr_a1_a2_o[m]   = wr_pd[m][6];
        assign bus.wr_na3_o[m]     = wr_pd[m][5];
        assign bus.wr_a3_o[m]      = wr_pd[m][4];
        assign bus.wr_na4_na5_o[m] = wr_pd[m][3];
        assign bus.wr_na4_a5_o[m]  = wr_pd[m][2];
        assign bus.wr_a4_na5_o[m]  = wr_pd[m][1];
        assign bus.wr_a4_a5_o[m]   = wr_pd[m][0];
        assign bus.wr_dat_arr_o[m] = wr_dat_q[m];
    end

    assign bus.wr_coll_o  = coll_q;
    assign bus.coll_cnt_o = cnt_q;
endmodule

// File: tb/tb_regfile_4r2w_64x24_ctl.sv
// Bench for regfile_4r2w_64x24_ctl with a behavioural model of the macro.
// Table of write/read vectors plus directed collision, bypass and reset cases.
module tb_regfile_4r2w_64x24_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    regfile_4r2w_64x24_ctl_if #(.CNT_W(8)) bus ();

    regfile_4r2w_64x24_ctl #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [11:0] wpd [2];
    logic [11:0] rpd [4];
    logic [3:0]  rv;
    logic [0:23] mem [64];

    for (genvar m = 0; m < 2; m++) begin : g_wpd
        assign wpd[m] = {bus.wr_c_na0_o[m], bus.wr_c_a0_o[m],
                         bus.wr_na1_na2_o[m], bus.wr_na1_a2_o[m],
                         bus.wr_a1_na2_o[m], bus.wr_a1_a2_o[m],
                         bus.wr_na3_o[m], bus.wr_a3_o[m],
                         bus.wr_na4_na5_o[m], bus.wr_na4_a5_o[m],
                         bus.wr_a4_na5_o[m], bus.wr_a4_a5_o[m]};
    end
    for (genvar n = 0; n < 4; n++) begin : g_rpd
        assign rpd[n] = {bus.rd_c_na0_o[n], bus.rd_c_a0_o[n],
                         bus.rd_na1_na2_o[n], bus.rd_na1_a2_o[n],
                         bus.rd_a1_na2_o[n], bus.rd_a1_a2_o[n],
                         bus.rd_na3_o[n], bus.rd_a3_o[n],
                         bus.rd_na4_na5_o[n], bus.rd_na4_a5_o[n],
                         bus.rd_a4_na5_o[n], bus.rd_a4_a5_o[n]};
        assign rv[n] = bus.rd_val_o[n];
    end

    function automatic logic [5:0] dec(input logic [11:0] p);
        return {p[10], p[7] | p[6], p[8] | p[6], p[4],
                p[1] | p[0], p[2] | p[0]};
    endfunction

    function automatic logic en_of(input logic [11:0] p);
        return p[11] | p[10];
    endfunction

    // Macro model: combinational read, write at the end of the launch cycle.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            bus.rd_dat_arr_i[n] = '0;
            if (en_of(rpd[n]))
                bus.rd_dat_arr_i[n] = mem[dec(rpd[n])];
        end
    end

    always @(posedge clk) begin
        if (en_of(wpd[0]))
            mem[dec(wpd[0])] <= bus.wr_dat_arr_o[0];
        if (en_of(wpd[1]))
            mem[dec(wpd[1])] <= bus.wr_dat_arr_o[1];
    end

    typedef struct {
        int          wp;
        int          rp;
        logic [5:0]  adr;
        logic [0:23] dat;
        logic [11:0] pd;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int n = 0; n < 4; n++) begin
            bus.rd_en_i[n]  = 1'b0;
            bus.rd_adr_i[n] = '0;
        end
        for (int m = 0; m < 2; m++) begin
            bus.wr_en_i[m]  = 1'b0;
            bus.wr_adr_i[m] = '0;
            bus.wr_dat_i[m] = '0;
        end
    endtask

    function automatic logic [11:0] pd_or();
        logic [11:0] o;
        o = wpd[0] | wpd[1];
        for (int n = 0; n < 4; n++)
            o = o | rpd[n];
        return o;
    endfunction

    logic [0:23] exp_byp;

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = '0;
        tbl[0] = '{0, 2, 6'h2D, 24'hA5A5A5, 12'b0101_0001_0100};
        tbl[1] = '{1, 0, 6'h00, 24'h123456, 12'b1010_0010_1000};
        tbl[2] = '{0, 1, 6'h3F, 24'hABCDEF, 12'b0100_0101_0001};
        tbl[3] = '{1, 3, 6'h12, 24'h0F0F0F, 12'b1000_1010_0010};
        tbl[4] = '{0, 0, 6'h27, 24'h777777, 12'b0110_0001_0001};
        tbl[5] = '{1, 2, 6'h19, 24'hFEDCBA, 12'b1000_0110_0100};

        clr();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_pd", 64'(pd_or()), 64'd0);
        chk("rst_val", 64'(rv), 64'd0);
        chk("rst_cnt", 64'(bus.coll_cnt_o), 64'd0);
        chk("rst_coll", 64'(bus.wr_coll_o), 64'd0);
        chk("rst_wdat", 64'(bus.wr_dat_arr_o[0] | bus.wr_dat_arr_o[1]), 64'd0);
        chk("rst_rdat", 64'(bus.rd_dat_o[0]), 64'd0);

        for (int i = 0; i < 6; i++) begin
            clr();
            bus.wr_en_i[tbl[i].wp]  = 1'b1;
            bus.wr_adr_i[tbl[i].wp] = tbl[i].adr;
            bus.wr_dat_i[tbl[i].wp] = tbl[i].dat;
            tick();
            chk($sformatf("v%0d_wpd", i), 64'(wpd[tbl[i].wp]), 64'(tbl[i].pd));
            chk($sformatf("v%0d_wpd_other", i), 64'(wpd[1 - tbl[i].wp]), 64'd0);
            chk($sformatf("v%0d_wdat", i),
                64'(bus.wr_dat_arr_o[tbl[i].wp]), 64'(tbl[i].dat));
            clr();
            bus.rd_en_i[tbl[i].rp]  = 1'b1;
            bus.rd_adr_i[tbl[i].rp] = tbl[i].adr;
            tick();
            clr();
            chk($sformatf("v%0d_rpd", i), 64'(rpd[tbl[i].rp]), 64'(tbl[i].pd));
            chk($sformatf("v%0d_val_early", i), 64'(rv), 64'd0);
            tick();
            chk($sformatf("v%0d_val", i), 64'(rv), 64'(4'b0001 << tbl[i].rp));
            chk($sformatf("v%0d_rdat", i),
                64'(bus.rd_dat_o[tbl[i].rp]), 64'(tbl[i].dat));
            tick();
            chk($sformatf("v%0d_val_drop", i), 64'(rv), 64'd0);
            chk($sformatf("v%0d_rdat_hold", i),
                64'(bus.rd_dat_o[tbl[i].rp]), 64'(tbl[i].dat));
        end

        // Write-write collision: wr1 wins, one-cycle pulse, count of one.
        clr();
        bus.wr_en_i[0] = 1'b1; bus.wr_adr_i[0] = 6'h07;
        bus.wr_dat_i[0] = 24'h111111;
        bus.wr_en_i[1] = 1'b1; bus.wr_adr_i[1] = 6'h07;
        bus.wr_dat_i[1] = 24'h222222;
        tick();
        clr();
        chk("coll_wpd0", 64'(wpd[0]), 64'd0);
        chk("coll_wpd1", 64'(wpd[1]), 64'(12'b1010_0001_0001));
        chk("coll_pulse", 64'(bus.wr_coll_o), 64'd1);
        chk("coll_cnt1", 64'(bus.coll_cnt_o), 64'd1);
        tick();
        chk("coll_pulse_end", 64'(bus.wr_coll_o), 64'd0);
        chk("coll_cnt_keep", 64'(bus.coll_cnt_o), 64'd1);
        bus.rd_en_i[0] = 1'b1; bus.rd_adr_i[0] = 6'h07;
        tick();
        clr();
        tick();
        chk("coll_rdat", 64'(bus.rd_dat_o[0]), 64'(24'h222222));
        chk("coll_rval", 64'(rv), 64'(4'b0001));

        // Sustained collisions saturate the counter at 8'hFF.
        bus.wr_en_i[0] = 1'b1; bus.wr_adr_i[0] = 6'h07;
        bus.wr_dat_i[0] = 24'h111111;
        bus.wr_en_i[1] = 1'b1; bus.wr_adr_i[1] = 6'h07;
        bus.wr_dat_i[1] = 24'h222222;
        repeat (253) tick();
        chk("sat_254", 64'(bus.coll_cnt_o), 64'd254);
        tick();
        chk("sat_255", 64'(bus.coll_cnt_o), 64'd255);
        repeat (46) tick();
        chk("sat_hold", 64'(bus.coll_cnt_o), 64'd255);
        clr();
        repeat (2) tick();
        chk("sat_idle", 64'(bus.coll_cnt_o), 64'd255);
        chk("sat_nopulse", 64'(bus.wr_coll_o), 64'd0);

        // Same-cycle write and read of 6'h3F (old contents 24'hABCDEF).
`ifdef REGFILE_CTL_BYPASS_EN
        exp_byp = 24'hC0FFEE;
`else
        exp_byp = 24'hABCDEF;
`endif
        bus.wr_en_i[1] = 1'b1; bus.wr_adr_i[1] = 6'h3F;
        bus.wr_dat_i[1] = 24'hC0FFEE;
        bus.rd_en_i[0] = 1'b1; bus.rd_adr_i[0] = 6'h3F;
        tick();
        clr();
        chk("byp_rpd", 64'(rpd[0]), 64'(12'b0100_0101_0001));
        tick();
        chk("byp_rdat", 64'(bus.rd_dat_o[0]), 64'(exp_byp));
        bus.rd_en_i[0] = 1'b1; bus.rd_adr_i[0] = 6'h3F;
        tick();
        clr();
        tick();
        chk("byp_after", 64'(bus.rd_dat_o[0]), 64'(24'hC0FFEE));

        // All four ports at one address.
        for (int n = 0; n < 4; n++) begin
            bus.rd_en_i[n] = 1'b1; bus.rd_adr_i[n] = 6'h2D;
        end
        tick();
        clr();
        tick();
        chk("multi_val", 64'(rv), 64'(4'hF));
        for (int n = 0; n < 4; n++)
            chk($sformatf("multi_rdat%0d", n),
                64'(bus.rd_dat_o[n]), 64'(24'hA5A5A5));

        // Reset with reads in flight and a request sampled during reset.
        for (int n = 0; n < 4; n++) begin
            bus.rd_en_i[n] = 1'b1; bus.rd_adr_i[n] = 6'h00;
        end
        tick();
        clr();
        rst = 1'b1;
        bus.rd_en_i[2] = 1'b1; bus.rd_adr_i[2] = 6'h00;
        tick();
        chk("mrst_val", 64'(rv), 64'd0);
        chk("mrst_pd", 64'(pd_or()), 64'd0);
        chk("mrst_cnt", 64'(bus.coll_cnt_o), 64'd0);
        chk("mrst_rdat", 64'(bus.rd_dat_o[0]), 64'd0);
        tick();
        rst = 1'b0;
        clr();
        chk("mrst_val2", 64'(rv), 64'd0);
        tick();
        chk("mrst_val3", 64'(rv), 64'd0);
        bus.rd_en_i[1] = 1'b1; bus.rd_adr_i[1] = 6'h00;
        tick();
        clr();
        chk("rec_val_early", 64'(rv), 64'd0);
        tick();
        chk("rec_val", 64'(rv), 64'(4'b0010));
        chk("rec_rdat", 64'(bus.rd_dat_o[1]), 64'(24'h123456));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
